// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port synchronous RAM.
// Define ARB_FIXED_PRIORITY_EN for fixed priority (port 0 wins ties); default is round-robin.
module mem_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Req0,
  input  logic                  Req1,
  input  logic                  Rw0,
  input  logic                  Rw1,
  input  logic [ADDR_WIDTH-1:0] Addr0,
  input  logic [ADDR_WIDTH-1:0] Addr1,
  input  logic [DATA_WIDTH-1:0] WData0,
  input  logic [DATA_WIDTH-1:0] WData1,
  output logic                  Gnt0,
  output logic                  Gnt1,
  output logic                  Done0,
  output logic                  Done1,
  output logic [DATA_WIDTH-1:0] RData0,
  output logic [DATA_WIDTH-1:0] RData1,
  output logic                  MemEnable,
  output logic                  MemReadWrite,
  output logic [ADDR_WIDTH-1:0] MemAddress,
  output logic [DATA_WIDTH-1:0] MemDataIn,
  input  logic [DATA_WIDTH-1:0] MemDataOut
);

  // state   | meaning
  // IDLE    | no owner; arbitrate pending requests
  // ACCESS  | MemEnable high; RAM acts at the closing edge
  // CAPTURE | read data on MemDataOut, register into winner's RData
  // RESP    | winner's Done high; grant released at exit edge
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t r_state;
  logic   r_winner;
  logic   r_last_grant;
  logic   w_any;
  logic   w_pick;

  assign w_any = Req0 | Req1;

  always_comb begin
    w_pick = Req1;
    if (Req0 && Req1) begin
`ifdef ARB_FIXED_PRIORITY_EN
      w_pick = 1'b0;
`else
      w_pick = ~r_last_grant;
`endif
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state      <= S_IDLE;
      r_winner     <= 1'b0;
      r_last_grant <= 1'b1;
      Gnt0         <= 1'b0;
      Gnt1         <= 1'b0;
      Done0        <= 1'b0;
      Done1        <= 1'b0;
      RData0       <= '0;
      RData1       <= '0;
      MemEnable    <= 1'b0;
      MemReadWrite <= 1'b0;
      MemAddress   <= '0;
      MemDataIn    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_winner     <= w_pick;
            MemEnable    <= 1'b1;
            MemReadWrite <= w_pick ? Rw1 : Rw0;
            MemAddress   <= w_pick ? Addr1 : Addr0;
            MemDataIn    <= w_pick ? WData1 : WData0;
            Gnt0         <= ~w_pick;
            Gnt1         <= w_pick;
            r_state      <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          MemEnable <= 1'b0;
          if (MemReadWrite) begin
            r_state <= S_CAPTURE;
          end else begin
            Done0   <= ~r_winner;
            Done1   <= r_winner;
            r_state <= S_RESP;
          end
        end
        S_CAPTURE: begin
          if (r_winner) RData1 <= MemDataOut;
          else          RData0 <= MemDataOut;
          Done0   <= ~r_winner;
          Done1   <= r_winner;
          r_state <= S_RESP;
        end
        S_RESP: begin
          Done0        <= 1'b0;
          Done1        <= 1'b0;
          Gnt0         <= 1'b0;
          Gnt1         <= 1'b0;
          r_last_grant <= r_winner;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural single-port RAM.
// Expectations follow ARB_FIXED_PRIORITY_EN when it is defined.
module tb_mem_arbiter;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Req0 = 1'b0, Req1 = 1'b0, Rw0 = 1'b0, Rw1 = 1'b0;
  logic [7:0] Addr0 = '0, Addr1 = '0, WData0 = '0, WData1 = '0;
  logic       Gnt0, Gnt1, Done0, Done1;
  logic [7:0] RData0, RData1;
  logic       MemEnable, MemReadWrite;
  logic [7:0] MemAddress, MemDataIn;
  logic [7:0] MemDataOut = '0;
  logic [7:0] ram [256] = '{default: 8'h00};

  typedef struct {
    bit         port;
    bit         rd;
    logic [7:0] data;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  always #5 Clock = ~Clock;

  mem_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .Clock(Clock), .Reset(Reset),
    .Req0(Req0), .Req1(Req1), .Rw0(Rw0), .Rw1(Rw1),
    .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
    .Gnt0(Gnt0), .Gnt1(Gnt1), .Done0(Done0), .Done1(Done1),
    .RData0(RData0), .RData1(RData1),
    .MemEnable(MemEnable), .MemReadWrite(MemReadWrite),
    .MemAddress(MemAddress), .MemDataIn(MemDataIn), .MemDataOut(MemDataOut)
  );

  always @(posedge Clock) begin
    if (MemEnable) begin
      if (MemReadWrite) MemDataOut <= ram[MemAddress];
      else              ram[MemAddress] <= MemDataIn;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // monitor: every Done pulse is matched against the oldest expected response
  always @(negedge Clock) begin
    exp_t e;
    if (Gnt0 || Gnt1) begin
      total++;
      if (Gnt0 && Gnt1) begin
        bad++;
        $display("FAIL both_gnt actual=11 required=one-hot");
      end
    end
    if (Done0 || Done1) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done actual=done0:%0b done1:%0b required=none", Done0, Done1);
      end else if (Done0 && Done1) begin
        bad++;
        void'(q.pop_front());
        $display("FAIL both_done actual=11 required=one-hot");
      end else begin
        e = q.pop_front();
        if (Done1 != e.port) begin
          bad++;
          $display("FAIL done_port actual=%0d required=%0d", Done1, e.port);
        end else if (e.rd && ((e.port ? RData1 : RData0) !== e.data)) begin
          bad++;
          $display("FAIL rdata%0d actual=%0h required=%0h", e.port,
                   e.port ? RData1 : RData0, e.data);
        end
      end
    end
  end

  task automatic set_port(input bit port, input bit req, input bit rw,
                          input logic [7:0] addr, input logic [7:0] wdata);
    if (port) begin Req1 = req; Rw1 = rw; Addr1 = addr; WData1 = wdata; end
    else      begin Req0 = req; Rw0 = rw; Addr0 = addr; WData0 = wdata; end
  endtask

  task automatic txn(input bit port, input bit rw, input logic [7:0] addr,
                     input logic [7:0] wdata, input logic [7:0] rexp, input bit change_mid);
    int n;
    bit seen;
    @(negedge Clock);
    set_port(port, 1'b1, rw, addr, wdata);
    q.push_back('{port: port, rd: rw, data: rexp});
    @(negedge Clock);
    chk("men_on", MemEnable, 1);
    chk("mem_rw", MemReadWrite, rw);
    chk("mem_addr", MemAddress, addr);
    if (!rw) chk("mem_din", MemDataIn, wdata);
    chk("gnt_win", port ? Gnt1 : Gnt0, 1);
    chk("gnt_lose", port ? Gnt0 : Gnt1, 0);
    if (change_mid) set_port(port, 1'b1, ~rw, addr ^ 8'hCC, wdata ^ 8'hFF);
    n = 1;
    seen = 1'b0;
    while (!seen && n < 10) begin
      @(negedge Clock);
      n++;
      if (n == 2) chk("men_off", MemEnable, 0);
      seen = port ? Done1 : Done0;
    end
    if (!seen) chk("done_timeout", 0, 1);
    else       chk("latency", n, rw ? 3 : 2);
    set_port(port, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    repeat (2) @(negedge Clock);
    chk("rst_gnt", {Gnt0, Gnt1, Done0, Done1, MemEnable, MemReadWrite}, 0);
    chk("rst_bus", {MemAddress, MemDataIn, RData0, RData1}, 0);
    Reset = 1'b0;

    txn(1'b0, 1'b0, 8'h00, 8'h55, 8'h00, 1'b0);
    txn(1'b1, 1'b1, 8'h00, 8'h00, 8'h55, 1'b0);
    txn(1'b0, 1'b0, 8'hFF, 8'hAA, 8'h00, 1'b1);
    chk("rdata1_held", RData1, 8'h55);
    txn(1'b0, 1'b1, 8'hFF, 8'h00, 8'hAA, 1'b0);
    txn(1'b1, 1'b1, 8'h33, 8'h00, 8'h00, 1'b0);
    chk("mem_hold_addr", MemAddress, 8'h33);

    // contention from a fresh reset
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
`ifdef ARB_FIXED_PRIORITY_EN
    for (int i = 0; i < 4; i++) q.push_back('{port: 1'b0, rd: 1'b0, data: 8'h00});
`else
    for (int i = 0; i < 4; i++) q.push_back('{port: i[0], rd: 1'b0, data: 8'h00});
`endif
    set_port(1'b0, 1'b1, 1'b0, 8'h10, 8'hA0);
    set_port(1'b1, 1'b1, 1'b0, 8'h20, 8'hB1);
    cnt = 0;
    for (int c = 0; c < 40 && cnt < 4; c++) begin
      @(negedge Clock);
      if (Done0 || Done1) cnt++;
    end
    chk("rr_done_count", cnt, 4);
    set_port(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_port(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(negedge Clock);

    // reset during ACCESS of a read
    set_port(1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    @(negedge Clock);
    chk("abort_men", MemEnable, 1);
    Reset = 1'b1;
    set_port(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge Clock);
    chk("abort_ctl", {Gnt0, Gnt1, Done0, Done1, MemEnable, MemReadWrite}, 0);
    chk("abort_bus", {MemAddress, MemDataIn, RData0, RData1}, 0);
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      chk("abort_nodone", {Done0, Done1}, 0);
    end
    txn(1'b1, 1'b1, 8'h10, 8'h00, 8'hA0, 1'b0);

    repeat (3) @(negedge Clock);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
